// File: rtl/ddr_wr_arbiter.sv
// ddr_wr_arbiter: round-robin sharing of one DDR AXI write port (AW + W)
// between N burst requesters. One burst is granted at a time. The winner's
// address/length are latched, the AW handshake is issued, and that
// requester's W data is routed until the DDR IP flags the last beat.
module ddr_wr_arbiter #(
   parameter int N  = 2,
   parameter int AW = 28,
   parameter int DW = 256
) (
   input  logic              ddr_clk,
   input  logic              rst,
   input  logic [N-1:0]      req_valid,
   input  logic [N*AW-1:0]   req_addr,
   input  logic [N*4-1:0]    req_len,
   input  logic [N*DW-1:0]   req_wdata,
   input  logic [N*DW/8-1:0] req_wstrb,
   output logic [N-1:0]      req_grant,
   output logic [N-1:0]      req_wready,
   output logic [N-1:0]      req_done,
   output logic [AW-1:0]     axi_awaddr,
   output logic [3:0]        axi_awlen,
   input  logic              axi_awready,
   output logic              axi_awvalid,
   output logic [DW-1:0]     axi_wdata,
   output logic [DW/8-1:0]   axi_wstrb,
   input  logic              axi_wready,
   input  logic              axi_wusero_last,
   output logic              busy,
   output logic              len_err
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int SW = DW / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [IW-1:0]  ptr;          // last winner; search starts just above it
   logic [IW-1:0]  gidx;         // index of the granted requester
   logic [IW-1:0]  win_idx;
   logic           win_found;
   logic [AW-1:0]  awaddr_r;
   logic [3:0]     awlen_r;
   logic [4:0]     beat_cnt;
   logic           done_r;
   logic           len_err_r;
   logic           last_beat;
   logic [N-1:0]   gnt_onehot;

   assign last_beat = (state == DATA) && axi_wready && axi_wusero_last;

   // Round-robin pick: first set req_valid bit from ptr+1 upward, wrapping.
   always_comb begin
      int idx;
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
      win_found = 1'b0;
      win_idx   = ptr;
      idx       = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win_idx   = IW'(idx);
         end
      end
   end

   // FSM state register.
   always_ff @(posedge ddr_clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM next-state: IDLE -> ADDR on any request, ADDR -> DATA on awready,
   // DATA -> IDLE on the accepted last beat.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (win_found)   state_nxt = ADDR;
         ADDR:    if (axi_awready) state_nxt = DATA;
         DATA:    if (last_beat)   state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   // Burst context: winner latch, beat counting, done pulse, sticky length error.
   always_ff @(posedge ddr_clk or posedge rst) begin
      if (rst) begin
         ptr       <= IW'(N - 1);
         gidx      <= '0;
         awaddr_r  <= '0;
         awlen_r   <= '0;
         beat_cnt  <= '0;
         done_r    <= 1'b0;
         len_err_r <= 1'b0;
      end else begin
         done_r <= last_beat;
         unique case (state)
            IDLE: begin
               if (win_found) begin
                  gidx     <= win_idx;
                  ptr      <= win_idx;
                  awaddr_r <= req_addr[win_idx*AW +: AW];
                  awlen_r  <= req_len[win_idx*4 +: 4];
               end
            end
            ADDR: begin
               if (axi_awready) beat_cnt <= '0;
            end
            DATA: begin
               if (axi_wready) beat_cnt <= beat_cnt + 5'd1;
               // Final count includes the beat accepted on this edge.
               if (last_beat && ((beat_cnt + 5'd1) != ({1'b0, awlen_r} + 5'd1)))
                  len_err_r <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign gnt_onehot  = N'(1) << gidx;
   assign busy        = (state != IDLE);
   assign req_grant   = busy ? gnt_onehot : '0;
   assign req_wready  = ((state == DATA) && axi_wready) ? gnt_onehot : '0;
   assign req_done    = done_r ? gnt_onehot : '0;
   assign axi_awvalid = (state == ADDR);
   assign axi_awaddr  = awaddr_r;
   assign axi_awlen   = awlen_r;
   assign axi_wdata   = busy ? req_wdata[gidx*DW +: DW] : '0;
   assign axi_wstrb   = busy ? req_wstrb[gidx*SW +: SW] : '0;
   assign len_err     = len_err_r;

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// tb_ddr_wr_arbiter: directed bench for ddr_wr_arbiter (N=2). Inputs are
// driven 1 ns after the rising edge and outputs are sampled 2 ns after it.
module tb_ddr_wr_arbiter;

   localparam int N  = 2;
   localparam int AW = 28;
   localparam int DW = 256;

   localparam logic [DW-1:0]   WD0   = {8{32'hA0A0_0001}};
   localparam logic [DW-1:0]   WD1   = {8{32'hB1B1_2222}};
   localparam logic [DW/8-1:0] WS0   = 32'hFFFF_FFFF;
   localparam logic [DW/8-1:0] WS1   = 32'h0F0F_0F0F;
   localparam logic [AW-1:0]   ADDR0 = 28'h0001000;
   localparam logic [AW-1:0]   ADDR1 = 28'h0002000;

   logic              ddr_clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N*AW-1:0]   req_addr;
   logic [N*4-1:0]    req_len;
   logic [N*DW-1:0]   req_wdata;
   logic [N*DW/8-1:0] req_wstrb;
   logic [N-1:0]      req_grant;
   logic [N-1:0]      req_wready;
   logic [N-1:0]      req_done;
   logic [AW-1:0]     axi_awaddr;
   logic [3:0]        axi_awlen;
   logic              axi_awready;
   logic              axi_awvalid;
   logic [DW-1:0]     axi_wdata;
   logic [DW/8-1:0]   axi_wstrb;
   logic              axi_wready;
   logic              axi_wusero_last;
   logic              busy;
   logic              len_err;

   int tests = 0;
   int fails = 0;

   ddr_wr_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
      .ddr_clk         (ddr_clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_addr        (req_addr),
      .req_len         (req_len),
      .req_wdata       (req_wdata),
      .req_wstrb       (req_wstrb),
      .req_grant       (req_grant),
      .req_wready      (req_wready),
      .req_done        (req_done),
      .axi_awaddr      (axi_awaddr),
      .axi_awlen       (axi_awlen),
      .axi_awready     (axi_awready),
      .axi_awvalid     (axi_awvalid),
      .axi_wdata       (axi_wdata),
      .axi_wstrb       (axi_wstrb),
      .axi_wready      (axi_wready),
      .axi_wusero_last (axi_wusero_last),
      .busy            (busy),
      .len_err         (len_err)
   );

   // 100 MHz clock.
   always #5 ddr_clk = ~ddr_clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge ddr_clk);
      #1;
   endtask

   // Entered 1 ns after the edge that moved the DUT into ADDR for requester g.
   // Holds awready low for aw_wait-1 cycles, then runs nbeats accepted beats
   // (wready toggling 1,0,1,0 when toggle=1) with last on the final beat, and
   // returns in the cycle after the last beat (the done cycle).
   task automatic do_burst(input int g, input int aw_wait, input int nbeats, input bit toggle,
                           input logic [AW-1:0] exp_addr, input logic [3:0] exp_len);
      logic [N-1:0]    oh;
      logic [DW-1:0]   exp_wd;
      logic [DW/8-1:0] exp_ws;
      int              acc;
      int              cyc;
      bit              wr;
      oh     = N'(1) << g;
      exp_wd = (g == 0) ? WD0 : WD1;
      exp_ws = (g == 0) ? WS0 : WS1;
      #1;
      check("grant_addr", req_grant, oh);
      check("busy_addr", busy, 1'b1);
      check("awaddr", axi_awaddr, exp_addr);
      check("awlen", axi_awlen, exp_len);
      for (int i = 0; i < aw_wait; i++) begin
         check("awvalid_hold", axi_awvalid, 1'b1);
         if (i == aw_wait - 1) axi_awready = 1'b1;
         tick();
      end
      axi_awready = 1'b0;
      #1;
      check("awvalid_drop", axi_awvalid, 1'b0);
      acc = 0;
      cyc = 0;
      while (acc < nbeats && cyc < 64) begin
         wr              = toggle ? (cyc % 2 == 0) : 1'b1;
         axi_wready      = wr;
         axi_wusero_last = wr && (acc + 1 == nbeats);
         #1;
         check("wdata", axi_wdata, exp_wd);
         check("wstrb", axi_wstrb, exp_ws);
         check("req_wready", req_wready, wr ? oh : '0);
         check("req_done_mid", req_done, '0);
         tick();
         if (wr) acc++;
         cyc++;
      end
      axi_wready      = 1'b0;
      axi_wusero_last = 1'b0;
      #1;
      check("req_done", req_done, oh);
      check("grant_clear", req_grant, '0);
      check("busy_clear", busy, 1'b0);
   endtask

   // Directed sequence.
   initial begin
      rst             = 1'b1;
      req_valid       = '0;
      req_addr        = {ADDR1, ADDR0};
      req_len         = {4'd3, 4'd3};
      req_wdata       = {WD1, WD0};
      req_wstrb       = {WS1, WS0};
      axi_awready     = 1'b0;
      axi_wready      = 1'b0;
      axi_wusero_last = 1'b0;

      // Reset values.
      #12;
      check("rst_grant", req_grant, '0);
      check("rst_done", req_done, '0);
      check("rst_awvalid", axi_awvalid, 1'b0);
      check("rst_awaddr", axi_awaddr, '0);
      check("rst_awlen", axi_awlen, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_len_err", len_err, 1'b0);
      check("rst_wstrb", axi_wstrb, '0);
      @(negedge ddr_clk);
      rst = 1'b0;
      tick();
      check("idle_busy", busy, 1'b0);

      // Both requesters held high: grants alternate 0,1,0,1.
      req_valid = 2'b11;
      tick();
      for (int b = 0; b < 4; b++) begin
         do_burst(b % 2, 1, 4, 1'b0, (b % 2 == 1) ? ADDR1 : ADDR0, 4'd3);
         if (b == 3) req_valid = '0;
         tick();
      end
      #1;
      check("rr_done_once", req_done, '0);
      check("rr_idle", busy, 1'b0);

      // Single request, len 7, awready after 3 cycles, 8 continuous beats.
      req_len   = {4'd7, 4'd7};
      req_valid = 2'b01;
      tick();
      req_valid = '0;
      do_burst(0, 3, 8, 1'b0, ADDR0, 4'd7);
      check("single_len_err", len_err, 1'b0);
      tick();
      #1;
      check("single_done_once", req_done, '0);
      check("single_stay_idle", busy, 1'b0);

      // wready toggling with len 3.
      req_len   = {4'd3, 4'd3};
      req_valid = 2'b01;
      tick();
      req_valid = '0;
      do_burst(0, 2, 4, 1'b1, ADDR0, 4'd3);
      check("toggle_len_err", len_err, 1'b0);
      tick();

      // Early last on beat 3 with len 7 sets the sticky error.
      req_len   = {4'd3, 4'd7};
      req_valid = 2'b01;
      tick();
      req_valid = '0;
      do_burst(0, 1, 3, 1'b0, ADDR0, 4'd7);
      check("early_len_err", len_err, 1'b1);
      tick();
      req_valid = 2'b10;
      tick();
      req_valid = '0;
      do_burst(1, 1, 4, 1'b0, ADDR1, 4'd3);
      check("sticky_len_err", len_err, 1'b1);
      tick();

      // Reset in DATA after 2 of 8 beats.
      req_len   = {4'd7, 4'd7};
      req_valid = 2'b01;
      tick();
      req_valid   = '0;
      axi_awready = 1'b1;
      tick();
      axi_awready = 1'b0;
      axi_wready  = 1'b1;
      #1;
      check("pre_rst_wready", req_wready, 2'b01);
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("arst_grant", req_grant, '0);
      check("arst_awvalid", axi_awvalid, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_wready", req_wready, '0);
      check("arst_len_err", len_err, 1'b0);
      axi_wready = 1'b0;
      @(negedge ddr_clk);
      rst       = 1'b0;
      req_len   = {4'd3, 4'd3};
      req_valid = 2'b11;
      tick();
      do_burst(0, 1, 4, 1'b0, ADDR0, 4'd3);

      // Requester 1 drops req_valid during ADDR; burst still completes.
      tick();
      req_valid = 2'b01;
      do_burst(1, 2, 4, 1'b0, ADDR1, 4'd3);
      tick();
      req_valid = '0;
      do_burst(0, 1, 4, 1'b0, ADDR0, 4'd3);
      tick();
      #1;
      check("final_idle", busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
